// File: rtl/cpu_types_pkg.sv
// Shared types for the data cache: address field widths,
// the address frame layout and the controller state enum.
package cpu_types_pkg;

   localparam int DC_SETS      = 8;
   localparam int DC_BLK_WORDS = 2;

   // Field widths derived from the cache geometry.
   function automatic int f_woff_w(input int bw);
      return $clog2(bw);
   endfunction

   function automatic int f_idx_w(input int sets);
      return $clog2(sets);
   endfunction

   function automatic int f_tag_w(input int sets, input int bw);
      return 30 - $clog2(sets) - $clog2(bw);
   endfunction

   localparam int DC_WOFF_W = f_woff_w(DC_BLK_WORDS);
   localparam int DC_IDX_W  = f_idx_w(DC_SETS);
   localparam int DC_TAG_W  = f_tag_w(DC_SETS, DC_BLK_WORDS);

   // Byte address layout for the default geometry.
   typedef struct packed {
      logic [DC_TAG_W-1:0]  tag;
      logic [DC_IDX_W-1:0]  idx;
      logic [DC_WOFF_W-1:0] woff;
      logic [1:0]           bytoff;
   } dcachef_t;

   typedef enum logic [2:0] {
      IDLE,
      WB,
      FILL,
      FLUSH_SCAN,
      FLUSH_WB,
      HALTED
   } dc_state_t;

endpackage

// File: rtl/dcache_assoc_if.sv
// Datapath and memory-side signals of the data cache.
// slave is the cache view, master the datapath/memory view.
interface dcache_assoc_if;

   logic        dmemREN;
   logic        dmemWEN;
   logic [31:0] dmemaddr;
   logic [31:0] dmemstore;
   logic        halt;
   logic        dhit;
   logic [31:0] dmemload;
   logic        flushed;
   logic        dREN;
   logic        dWEN;
   logic [31:0] daddr;
   logic [31:0] dstore;
   logic        dwait;
   logic [31:0] dload;

   modport slave (
      input  dmemREN, dmemWEN, dmemaddr, dmemstore, halt,
      input  dwait, dload,
      output dhit, dmemload, flushed,
      output dREN, dWEN, daddr, dstore
   );

   modport master (
      output dmemREN, dmemWEN, dmemaddr, dmemstore, halt,
      output dwait, dload,
      input  dhit, dmemload, flushed,
      input  dREN, dWEN, daddr, dstore
   );

endinterface

// File: rtl/dcache_way.sv
// One way of the data cache: valid/dirty/tag per set and
// BLK_WORDS data words, with a combinational tag compare.
module dcache_way
   import cpu_types_pkg::*;
#(
   parameter  int SETS      = DC_SETS,
   parameter  int BLK_WORDS = DC_BLK_WORDS,
   localparam int WOW       = f_woff_w(BLK_WORDS),
   localparam int IW        = f_idx_w(SETS),
   localparam int TW        = f_tag_w(SETS, BLK_WORDS)
) (
   input  logic                 CLK,
   input  logic                 nRST,
   input  logic [IW-1:0]        i_idx,
   input  logic [WOW-1:0]       i_woff,
   input  logic [TW-1:0]        i_tag,
   input  logic [BLK_WORDS-1:0] i_wen,
   input  logic [31:0]          i_wdata,
   input  logic                 i_set_dirty,
   input  logic                 i_clr_dirty,
   input  logic                 i_fill,
   output logic                 o_hit,
   output logic                 o_valid,
   output logic                 o_dirty,
   output logic [TW-1:0]        o_tag,
   output logic [31:0]          o_word
);

   logic [SETS-1:0] r_valid;
   logic [SETS-1:0] r_dirty;
   logic [TW-1:0]   r_tag  [SETS];
   logic [31:0]     r_data [SETS][BLK_WORDS];

   // Lookup of the selected set and word.
   always_comb begin
      o_valid = r_valid[i_idx];
      o_dirty = r_dirty[i_idx];
      o_tag   = r_tag[i_idx];
      o_word  = r_data[i_idx][i_woff];
      o_hit   = r_valid[i_idx] && (r_tag[i_idx] == i_tag);
   end

   // Storage update: word writes, fill completion, dirty tracking.
   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         r_valid <= '0;
         r_dirty <= '0;
         for (int s = 0; s < SETS; s++) begin
            r_tag[s] <= '0;
            for (int w = 0; w < BLK_WORDS; w++)
               r_data[s][w] <= '0;
         end
      end else begin
         for (int w = 0; w < BLK_WORDS; w++)
            if (i_wen[w])
               r_data[i_idx][w] <= i_wdata;
         if (i_fill) begin
            r_valid[i_idx] <= 1'b1;
            r_dirty[i_idx] <= 1'b0;
            r_tag[i_idx]   <= i_tag;
         end else if (i_set_dirty) begin
            r_dirty[i_idx] <= 1'b1;
         end else if (i_clr_dirty) begin
            r_dirty[i_idx] <= 1'b0;
         end
      end
   end

endmodule

// File: rtl/dcache_assoc.sv
// Two-way set-associative write-back data cache with LRU
// replacement and a halt-triggered flush of dirty blocks.
module dcache_assoc
   import cpu_types_pkg::*;
#(
   parameter int SETS      = DC_SETS,
   parameter int BLK_WORDS = DC_BLK_WORDS,
   parameter int CPUID     = 0
) (
   input  logic         CLK,
   input  logic         nRST,
   dcache_assoc_if.slave bus
);

   localparam int WOW = f_woff_w(BLK_WORDS);
   localparam int IW  = f_idx_w(SETS);
   localparam int TW  = f_tag_w(SETS, BLK_WORDS);
   localparam logic [WOW-1:0] LAST_W = WOW'(BLK_WORDS - 1);
   localparam logic [IW-1:0]  LAST_S = IW'(SETS - 1);

   dc_state_t       r_state;
   logic [WOW-1:0]  r_cnt;
   logic            r_victim;
   logic [IW-1:0]   r_fset;
   logic            r_fway;
   logic            r_halt;
   logic [SETS-1:0] r_lru;

   logic [WOW-1:0] w_req_woff;
   logic [IW-1:0]  w_req_idx;
   logic [TW-1:0]  w_req_tag;
   logic           w_rd;
   logic           w_wr;
   logic           w_req;
   logic [IW-1:0]  w_idx;
   logic [WOW-1:0] w_woff;
   logic           w_any_hit;
   logic           w_hway;
   logic           w_bway;
   logic           w_lway;
   logic           w_last;
   logic           w_last_pair;
   logic           w_xfer;
   logic [31:0]    w_wdata;
   logic           w_unused_bits;

   logic [1:0][BLK_WORDS-1:0] w_wen;
   logic [1:0]                w_set_dirty;
   logic [1:0]                w_clr_dirty;
   logic [1:0]                w_fill;
   logic [1:0]                w_hit;
   logic [1:0]                w_valid;
   logic [1:0]                w_dirty;
   logic [1:0][TW-1:0]        w_tag;
   logic [1:0][31:0]          w_word;

   assign w_req_woff = bus.dmemaddr[2 +: WOW];
   assign w_req_idx  = bus.dmemaddr[2+WOW +: IW];
   assign w_req_tag  = bus.dmemaddr[31 -: TW];
   assign w_unused_bits = ^bus.dmemaddr[1:0];

   // Simultaneous read and write requests are served as reads.
   assign w_rd  = bus.dmemREN;
   assign w_wr  = bus.dmemWEN & ~bus.dmemREN;
   assign w_req = w_rd | w_wr;

   assign w_idx = (r_state == FLUSH_SCAN || r_state == FLUSH_WB)
                ? r_fset : w_req_idx;
   assign w_woff = (r_state == IDLE) ? w_req_woff : r_cnt;

   assign w_any_hit   = w_hit[0] | w_hit[1];
   assign w_hway      = w_hit[1];
   assign w_lway      = r_lru[w_req_idx];
   assign w_bway      = (r_state == FLUSH_WB) ? r_fway : r_victim;
   assign w_last      = (r_cnt == LAST_W);
   assign w_last_pair = r_fway && (r_fset == LAST_S);
   assign w_xfer      = ~bus.dwait;

   for (genvar g = 0; g < 2; g++) begin : g_way
      dcache_way #(
         .SETS      (SETS),
         .BLK_WORDS (BLK_WORDS)
      ) u_way (
         .CLK         (CLK),
         .nRST        (nRST),
         .i_idx       (w_idx),
         .i_woff      (w_woff),
         .i_tag       (w_req_tag),
         .i_wen       (w_wen[g]),
         .i_wdata     (w_wdata),
         .i_set_dirty (w_set_dirty[g]),
         .i_clr_dirty (w_clr_dirty[g]),
         .i_fill      (w_fill[g]),
         .o_hit       (w_hit[g]),
         .o_valid     (w_valid[g]),
         .o_dirty     (w_dirty[g]),
         .o_tag       (w_tag[g]),
         .o_word      (w_word[g])
      );
   end

   // Per-state bus outputs and way write controls.
   always_comb begin
      bus.dhit     = 1'b0;
      bus.dmemload = '0;
      bus.flushed  = (r_state == HALTED);
      bus.dREN     = 1'b0;
      bus.dWEN     = 1'b0;
      bus.daddr    = '0;
      bus.dstore   = '0;
      w_wen        = '0;
      w_set_dirty  = '0;
      w_clr_dirty  = '0;
      w_fill       = '0;
      w_wdata      = bus.dmemstore;
      unique case (r_state)
         IDLE: begin
            if (w_req && w_any_hit) begin
               bus.dhit     = 1'b1;
               bus.dmemload = w_word[w_hway];
               if (w_wr) begin
                  w_wen[w_hway][w_req_woff] = 1'b1;
                  w_set_dirty[w_hway]       = 1'b1;
               end
            end
         end
         WB, FLUSH_WB: begin
            bus.dWEN   = 1'b1;
            bus.daddr  = {w_tag[w_bway], w_idx, r_cnt, 2'b00};
            bus.dstore = w_word[w_bway];
            if (r_state == FLUSH_WB && w_xfer && w_last)
               w_clr_dirty[r_fway] = 1'b1;
         end
         FILL: begin
            bus.dREN = 1'b1;
            bus.daddr = {w_req_tag, w_idx, r_cnt, 2'b00};
            w_wdata  = bus.dload;
            if (w_xfer) begin
               w_wen[r_victim][r_cnt] = 1'b1;
               if (w_last)
                  w_fill[r_victim] = 1'b1;
            end
         end
         default: ;
      endcase
   end

   // Controller FSM: miss handling, LRU and flush walk.
   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         r_state  <= IDLE;
         r_cnt    <= '0;
         r_victim <= 1'b0;
         r_fset   <= '0;
         r_fway   <= 1'b0;
         r_halt   <= 1'b0;
         r_lru    <= '0;
      end else begin
         r_halt <= r_halt | bus.halt;
         unique case (r_state)
            IDLE: begin
               if (w_req) begin
                  if (w_any_hit) begin
                     r_lru[w_req_idx] <= ~w_hway;
                  end else begin
                     r_victim <= w_lway;
                     r_cnt    <= '0;
                     if (w_valid[w_lway] && w_dirty[w_lway])
                        r_state <= WB;
                     else
                        r_state <= FILL;
                  end
               end else if (r_halt || bus.halt) begin
                  r_state <= FLUSH_SCAN;
                  r_fset  <= '0;
                  r_fway  <= 1'b0;
               end
            end
            WB: begin
               if (w_xfer) begin
                  if (w_last) begin
                     r_cnt   <= '0;
                     r_state <= FILL;
                  end else begin
                     r_cnt <= r_cnt + 1'b1;
                  end
               end
            end
            FILL: begin
               if (w_xfer) begin
                  if (w_last) begin
                     r_cnt   <= '0;
                     r_state <= IDLE;
                  end else begin
                     r_cnt <= r_cnt + 1'b1;
                  end
               end
            end
            FLUSH_SCAN: begin
               if (w_valid[r_fway] && w_dirty[r_fway]) begin
                  r_cnt   <= '0;
                  r_state <= FLUSH_WB;
               end else if (w_last_pair) begin
                  r_state <= HALTED;
               end else begin
                  r_fway <= ~r_fway;
                  if (r_fway)
                     r_fset <= r_fset + 1'b1;
               end
            end
            FLUSH_WB: begin
               if (w_xfer) begin
                  if (w_last) begin
                     r_cnt <= '0;
                     if (w_last_pair) begin
                        r_state <= HALTED;
                     end else begin
                        r_state <= FLUSH_SCAN;
                        r_fway  <= ~r_fway;
                        if (r_fway)
                           r_fset <= r_fset + 1'b1;
                     end
                  end else begin
                     r_cnt <= r_cnt + 1'b1;
                  end
               end
            end
            HALTED: ;
            default: r_state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_dcache_assoc.sv
// Directed bench for dcache_assoc: misses, evictions,
// stalls, flush on halt and reset during a fill.
module tb_dcache_assoc;

   logic CLK = 1'b0;
   logic nRST;

   always #5 CLK = ~CLK;

   dcache_assoc_if bus();

   dcache_assoc #(
      .SETS      (8),
      .BLK_WORDS (2),
      .CPUID     (0)
   ) u_dut (
      .CLK  (CLK),
      .nRST (nRST),
      .bus  (bus)
   );

   int n_vec = 0;
   int n_err = 0;
   int wait_cycles = 0;
   int stall = 0;
   int hold_seen = 0;
   int hold_bad = 0;
   int both_bad = 0;

   logic [31:0]   mem [1024];
   logic [1023:0] mem_v = '0;
   logic          q_we   [$];
   logic [31:0]   q_addr [$];
   logic [31:0]   q_data [$];
   logic [31:0]   p_addr = '0;
   logic [31:0]   p_data = '0;
   logic [1:0]    p_rw = '0;

   function automatic logic [31:0] f_init(input logic [31:0] a);
      return 32'h5A00_0000 ^ a;
   endfunction

   assign bus.dwait = (bus.dREN | bus.dWEN) && (stall < wait_cycles);

   always_comb begin
      bus.dload = '0;
      if (bus.dREN) begin
         if (mem_v[bus.daddr[11:2]])
            bus.dload = mem[bus.daddr[11:2]];
         else
            bus.dload = f_init({bus.daddr[31:2], 2'b00});
      end
   end

   // Memory model: logs each transfer, tracks stall stability.
   always @(posedge CLK) begin
      if (bus.dREN && bus.dWEN)
         both_bad <= both_bad + 1;
      if (nRST && (bus.dREN || bus.dWEN)) begin
         if (stall > 0) begin
            hold_seen <= hold_seen + 1;
            if (bus.daddr !== p_addr || bus.dstore !== p_data ||
                {bus.dREN, bus.dWEN} !== p_rw)
               hold_bad <= hold_bad + 1;
         end
         p_addr <= bus.daddr;
         p_data <= bus.dstore;
         p_rw   <= {bus.dREN, bus.dWEN};
         if (!bus.dwait) begin
            q_we.push_back(bus.dWEN);
            q_addr.push_back(bus.daddr);
            q_data.push_back(bus.dWEN ? bus.dstore : bus.dload);
            if (bus.dWEN) begin
               mem[bus.daddr[11:2]]   <= bus.dstore;
               mem_v[bus.daddr[11:2]] <= 1'b1;
            end
            stall <= 0;
         end else begin
            stall <= stall + 1;
         end
      end else begin
         stall <= 0;
      end
   end

   task automatic check(input string tag, input logic [31:0] got,
                        input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic exp_xfer(input int i, input logic we,
                           input logic [31:0] a, input logic [31:0] d);
      if (i >= q_addr.size()) begin
         check("xfer_missing", 32'(q_addr.size()), 32'(i + 1));
      end else begin
         check("xfer_we", {31'b0, q_we[i]}, {31'b0, we});
         check("xfer_addr", q_addr[i], a);
         check("xfer_data", q_data[i], d);
      end
   endtask

   task automatic do_req(input logic wr, input logic [31:0] addr,
                         input logic [31:0] wdata,
                         output logic [31:0] rdata, output int cyc);
      logic got;
      bus.dmemaddr  = addr;
      bus.dmemstore = wdata;
      bus.dmemREN   = ~wr;
      bus.dmemWEN   = wr;
      cyc   = 0;
      rdata = '0;
      got   = 1'b0;
      for (int k = 0; k < 400; k++) begin
         @(negedge CLK);
         if (bus.dhit) begin
            rdata = bus.dmemload;
            got   = 1'b1;
            break;
         end
         cyc++;
      end
      check("req_done", {31'b0, got}, 32'd1);
      @(posedge CLK);
      #1;
      bus.dmemREN = 1'b0;
      bus.dmemWEN = 1'b0;
   endtask

   task automatic chk_quiet(input string tag);
      check({tag, "_dREN"}, {31'b0, bus.dREN}, 32'd0);
      check({tag, "_dWEN"}, {31'b0, bus.dWEN}, 32'd0);
      check({tag, "_daddr"}, bus.daddr, 32'd0);
      check({tag, "_dstore"}, bus.dstore, 32'd0);
      check({tag, "_dhit"}, {31'b0, bus.dhit}, 32'd0);
      check({tag, "_dmemload"}, bus.dmemload, 32'd0);
   endtask

   initial begin
      logic [31:0] rd;
      int cyc;
      int b;
      logic seen;

      nRST          = 1'b0;
      bus.dmemREN   = 1'b0;
      bus.dmemWEN   = 1'b0;
      bus.dmemaddr  = '0;
      bus.dmemstore = '0;
      bus.halt      = 1'b0;
      repeat (2) @(negedge CLK);
      chk_quiet("rst");
      check("rst_flushed", {31'b0, bus.flushed}, 32'd0);
      @(posedge CLK);
      #1 nRST = 1'b1;
      @(posedge CLK);
      #1;

      // Cold read: two-word fill, then hit.
      b = q_addr.size();
      do_req(1'b0, 32'h100, '0, rd, cyc);
      check("cold_data", rd, f_init(32'h100));
      check("cold_lat", {31'b0, cyc >= 3}, 32'd1);
      check("cold_nxfer", 32'(q_addr.size() - b), 32'd2);
      exp_xfer(b + 0, 1'b0, 32'h100, f_init(32'h100));
      exp_xfer(b + 1, 1'b0, 32'h104, f_init(32'h104));

      // Store hit and read back: no memory traffic.
      b = q_addr.size();
      do_req(1'b1, 32'h100, 32'hDEAD, rd, cyc);
      check("st_lat", 32'(cyc), 32'd0);
      do_req(1'b0, 32'h100, '0, rd, cyc);
      check("ld_dead", rd, 32'hDEAD);
      check("ld_lat", 32'(cyc), 32'd0);
      check("hit_nxfer", 32'(q_addr.size() - b), 32'd0);

      // Same-set misses: second one evicts the dirty block.
      b = q_addr.size();
      do_req(1'b0, 32'h200, '0, rd, cyc);
      check("r200_data", rd, f_init(32'h200));
      check("r200_nxfer", 32'(q_addr.size() - b), 32'd2);
      b = q_addr.size();
      do_req(1'b0, 32'h300, '0, rd, cyc);
      check("r300_data", rd, f_init(32'h300));
      check("r300_lat", {31'b0, cyc >= 5}, 32'd1);
      check("r300_nxfer", 32'(q_addr.size() - b), 32'd4);
      exp_xfer(b + 0, 1'b1, 32'h100, 32'hDEAD);
      exp_xfer(b + 1, 1'b1, 32'h104, f_init(32'h104));
      exp_xfer(b + 2, 1'b0, 32'h300, f_init(32'h300));
      exp_xfer(b + 3, 1'b0, 32'h304, f_init(32'h304));

      // Dirty both ways, then a stalled miss with writeback.
      do_req(1'b1, 32'h204, 32'h1234, rd, cyc);
      check("st204_lat", 32'(cyc), 32'd0);
      do_req(1'b1, 32'h300, 32'h5555, rd, cyc);
      check("st300_lat", 32'(cyc), 32'd0);
      wait_cycles = 5;
      b = q_addr.size();
      do_req(1'b0, 32'h400, '0, rd, cyc);
      check("r400_data", rd, f_init(32'h400));
      check("r400_lat", {31'b0, cyc >= 25}, 32'd1);
      check("r400_nxfer", 32'(q_addr.size() - b), 32'd4);
      exp_xfer(b + 0, 1'b1, 32'h200, f_init(32'h200));
      exp_xfer(b + 1, 1'b1, 32'h204, 32'h1234);
      exp_xfer(b + 2, 1'b0, 32'h400, f_init(32'h400));
      exp_xfer(b + 3, 1'b0, 32'h404, f_init(32'h404));
      check("stall_seen", {31'b0, hold_seen >= 16}, 32'd1);
      check("stall_stable", 32'(hold_bad), 32'd0);
      wait_cycles = 0;

      // Second dirty block in set 1, then halt and flush.
      b = q_addr.size();
      do_req(1'b1, 32'h148, 32'hBEEF, rd, cyc);
      check("w148_nxfer", 32'(q_addr.size() - b), 32'd2);
      exp_xfer(b + 0, 1'b0, 32'h148, f_init(32'h148));
      b = q_addr.size();
      bus.halt = 1'b1;
      seen = 1'b0;
      for (int k = 0; k < 100; k++) begin
         @(negedge CLK);
         if (bus.flushed) begin
            seen = 1'b1;
            break;
         end
      end
      check("flushed", {31'b0, seen}, 32'd1);
      check("flush_nxfer", 32'(q_addr.size() - b), 32'd4);
      exp_xfer(b + 0, 1'b1, 32'h300, 32'h5555);
      exp_xfer(b + 1, 1'b1, 32'h304, f_init(32'h304));
      exp_xfer(b + 2, 1'b1, 32'h148, 32'hBEEF);
      exp_xfer(b + 3, 1'b1, 32'h14C, f_init(32'h14C));
      bus.halt = 1'b0;
      repeat (5) @(negedge CLK);
      check("flushed_held", {31'b0, bus.flushed}, 32'd1);
      check("halt_dREN", {31'b0, bus.dREN}, 32'd0);
      check("halt_dWEN", {31'b0, bus.dWEN}, 32'd0);
      check("halt_nxfer", 32'(q_addr.size() - b), 32'd4);

      // Reset in the middle of a stalled fill.
      nRST = 1'b0;
      @(posedge CLK);
      #1 nRST = 1'b1;
      check("rst2_flushed", {31'b0, bus.flushed}, 32'd0);
      wait_cycles   = 3;
      bus.dmemaddr  = 32'h100;
      bus.dmemREN   = 1'b1;
      seen = 1'b0;
      for (int k = 0; k < 50; k++) begin
         @(negedge CLK);
         if (bus.dREN) begin
            seen = 1'b1;
            break;
         end
      end
      check("fill_start", {31'b0, seen}, 32'd1);
      @(negedge CLK);
      #1 nRST = 1'b0;
      #1;
      chk_quiet("midrst");
      check("midrst_flushed", {31'b0, bus.flushed}, 32'd0);
      bus.dmemREN = 1'b0;
      @(posedge CLK);
      #1 nRST = 1'b1;
      wait_cycles = 0;
      @(posedge CLK);
      #1;
      b = q_addr.size();
      do_req(1'b0, 32'h100, '0, rd, cyc);
      check("rerd_data", rd, 32'hDEAD);
      check("rerd_lat", {31'b0, cyc >= 3}, 32'd1);
      check("rerd_nxfer", 32'(q_addr.size() - b), 32'd2);
      exp_xfer(b + 0, 1'b0, 32'h100, 32'hDEAD);
      check("rw_exclusive", 32'(both_bad), 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==",
               n_vec, n_err);
      $finish;
   end

endmodule
